// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus bundle: imem read port, redirect request,
// IR valid/ready handshake and the halt status flag.
// The master side is the fetch unit; the slave side is imem plus decode.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16
);
  logic              imem_rd_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              ir_valid;
  logic              ir_ready;
  logic [31:0]       ir_data;
  logic [ADDR_W-1:0] ir_pc;
  logic              halted;

  modport master (
    output imem_rd_en, imem_addr, ir_valid, ir_data, ir_pc, halted,
    input  imem_rdata, redirect_valid, redirect_pc, ir_ready
  );

  modport slave (
    input  imem_rd_en, imem_addr, ir_valid, ir_data, ir_pc, halted,
    output imem_rdata, redirect_valid, redirect_pc, ir_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word reads to a synchronous imem (1-cycle
// read latency), buffers responses in a small FIFO and hands them to decode
// in program order over a valid/ready handshake. Redirects flush everything.
// Optional halt support is enabled by defining FETCH_HALT_EN: a fetched word
// whose opcode field equals HALT_OPCODE stops further fetching until redirect.
module instr_fetch_unit #(
  parameter int                ADDR_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
`ifdef FETCH_HALT_EN
  ,
  parameter logic [4:0]        HALT_OPCODE = 5'h1F
`endif
) (
  input logic               clk,
  input logic               sys_rst,
  instr_fetch_unit_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef FETCH_HALT_EN
  typedef enum logic [0:0] {RUN = 1'b0, HALTED = 1'b1} state_t;
`else
  typedef enum logic [0:0] {RUN = 1'b0} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              has_room;
  logic              halt_hit;
  logic              issue;
  logic              do_pop;
  logic              head_valid;

  // Room is reserved for the in-flight response so the FIFO can never overflow.
  assign has_room   = (count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);
  assign head_valid = (count != '0);
  assign do_pop     = head_valid && bus.ir_ready;

`ifdef FETCH_HALT_EN
  // A halt word arriving this cycle blocks the fetch that would overlap it,
  // so pc stops at halt+1.
  assign halt_hit = inflight && (bus.imem_rdata[31:27] == HALT_OPCODE);
`else
  assign halt_hit = 1'b0;
`endif

  assign issue = !sys_rst && !bus.redirect_valid && (state == RUN) &&
                 has_room && !halt_hit;

  assign bus.imem_rd_en = issue;
  assign bus.imem_addr  = pc;
  assign bus.ir_valid   = head_valid;
  assign bus.ir_data    = head_valid ? fifo_data[rd_ptr] : 32'h0;
  assign bus.ir_pc      = head_valid ? fifo_pc[rd_ptr] : '0;

`ifdef FETCH_HALT_EN
  logic halted_q;
  assign bus.halted = halted_q;
`else
  assign bus.halted = 1'b0;
`endif

  // Fetch FSM, PC advance, in-flight tracking and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
`ifdef FETCH_HALT_EN
      halted_q    <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      // Flush buffer and drop any response in flight; a same-cycle pop is lost.
      state    <= RUN;
      pc       <= bus.redirect_pc;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
`ifdef FETCH_HALT_EN
      halted_q <= 1'b0;
`endif
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= bus.imem_rdata;
        fifo_pc[wr_ptr]   <= inflight_pc;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count + CNT_W'(inflight) - CNT_W'(do_pop);
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + ADDR_W'(1);
      end
`ifdef FETCH_HALT_EN
      if (halt_hit) begin
        state    <= HALTED;
        halted_q <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with an in-order scoreboard.
// Expected {pc, data} words are queued whenever reset or a redirect is
// driven and popped whenever decode accepts a word. The halt scenario is
// only exercised when FETCH_HALT_EN is defined.
module tb_instr_fetch_unit;

  localparam int ADDR_W = 16;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic sys_rst;
  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   delivered = 0;
  bit   halt_mode = 1'b0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W    (ADDR_W),
    .FIFO_DEPTH(4),
    .RESET_PC  (16'h0000)
  ) dut (
    .clk    (clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  function automatic logic [31:0] imem_word(input logic [15:0] addr);
    if (halt_mode && addr == 16'd3) return 32'hF800_0000;
    return 32'hA000_0000 + {16'h0000, addr};
  endfunction

  // Synchronous imem: data is only meaningful the cycle after a read strobe.
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_rdata <= imem_word(bus.imem_addr);
    else                bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic checkValue(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic fillExpected(input logic [15:0] start);
    exp_t        e;
    logic [15:0] p;
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      p      = start + 16'(i);
      e.pc   = p;
      e.data = imem_word(p);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: a word offered while ready is high is consumed at the next edge.
  task automatic checkOutput();
    exp_t e;
    if (!sys_rst && bus.ir_valid && bus.ir_ready) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("[TB] FAIL sb_extra observed pc=0x%04h expected no word", bus.ir_pc);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkValue("sb_pc", 32'(bus.ir_pc), 32'(e.pc));
        checkValue("sb_data", bus.ir_data, e.data);
        delivered++;
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, sample before the rising edge.
  task automatic applyStimulus(input logic rst, input logic ready,
                               input logic redir, input logic [15:0] rpc);
    @(negedge clk);
    sys_rst            = rst;
    bus.ir_ready       = ready;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
    checkOutput();
    if (rst)        fillExpected(16'h0000);
    else if (redir) fillExpected(rpc);
  endtask

  initial begin
    sys_rst            = 1'b1;
    bus.ir_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    $display("[TB] reset and streaming");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    checkBit("rst_ir_valid", bus.ir_valid, 1'b0);
    checkValue("rst_ir_data", bus.ir_data, 32'h0);
    checkValue("rst_ir_pc", 32'(bus.ir_pc), 32'h0);
    checkBit("rst_halted", bus.halted, 1'b0);
    checkBit("rst_rd_en", bus.imem_rd_en, 1'b0);
    delivered = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkBit("lat_c0_valid", bus.ir_valid, 1'b0);
    checkBit("lat_c0_rd_en", bus.imem_rd_en, 1'b1);
    checkValue("lat_c0_addr", 32'(bus.imem_addr), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkBit("lat_c1_valid", bus.ir_valid, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkBit("lat_c2_valid", bus.ir_valid, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
      checkBit("stream_valid", bus.ir_valid, 1'b1);
    end
    checkValue("p1_delivered", 32'(delivered), 32'd6);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    delivered = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      if (i >= 2) checkValue("bp_head_pc", 32'(bus.ir_pc), 32'h0);
      if (i >= 4) checkBit("bp_rd_en_low", bus.imem_rd_en, 1'b0);
    end
    checkValue("bp_head_data", bus.ir_data, 32'hA000_0000);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("bp_delivered", 32'(delivered), 32'd8);

    $display("[TB] redirect with full pipeline");
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0040);
    checkBit("rd_pre_valid", bus.ir_valid, 1'b1);
    checkValue("rd_pre_pc", 32'(bus.ir_pc), 32'h0);
    checkBit("rd_no_fetch", bus.imem_rd_en, 1'b0);
    delivered = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkBit("rd_flushed", bus.ir_valid, 1'b0);
    checkBit("rd_restart_en", bus.imem_rd_en, 1'b1);
    checkValue("rd_restart_addr", 32'(bus.imem_addr), 32'h0040);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkBit("rd_c1_valid", bus.ir_valid, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("rd_delivered", 32'(delivered), 32'd4);

    $display("[TB] pc wrap");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFE);
    delivered = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("wrap_delivered", 32'(delivered), 32'd4);

    $display("[TB] back-to-back redirects");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0080);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020);
    delivered = 0;
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("b2b_delivered", 32'(delivered), 32'd3);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    checkBit("mid_rst_valid_before", bus.ir_valid, 1'b1);
    checkBit("mid_rst_rd_en", bus.imem_rd_en, 1'b0);
    delivered = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkBit("mid_rst_valid", bus.ir_valid, 1'b0);
    checkValue("mid_rst_data", bus.ir_data, 32'h0);
    checkValue("mid_rst_pc", 32'(bus.ir_pc), 32'h0);
    checkValue("mid_rst_addr", 32'(bus.imem_addr), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkBit("mid_rst_c1_valid", bus.ir_valid, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("mid_rst_delivered", 32'(delivered), 32'd4);

`ifdef FETCH_HALT_EN
    $display("[TB] halt opcode");
    halt_mode = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    delivered = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
      if (i >= 5) begin
        checkBit("halt_rd_en", bus.imem_rd_en, 1'b0);
        checkBit("halt_flag", bus.halted, 1'b1);
        checkValue("halt_pc", 32'(bus.imem_addr), 32'h4);
      end
    end
    checkValue("halt_delivered", 32'(delivered), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0010);
    delivered = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkBit("unhalt_flag", bus.halted, 1'b0);
    checkBit("unhalt_rd_en", bus.imem_rd_en, 1'b1);
    checkValue("unhalt_addr", 32'(bus.imem_addr), 32'h0010);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    checkValue("unhalt_delivered", 32'(delivered), 32'd2);
`else
    checkBit("halted_tied_low", bus.halted, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
